// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared constants and types for the VLIW pipeline
package vliw_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 3;

  // Writeback architectural state
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  // Little-endian byte lane selects (lane 0 = bits 7:0)
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational byte-lane select and extend for loads
module load_align #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] readData,
  input  logic [1:0]        addr,
  input  logic              loadByte,
  input  logic              loadSigned,
  output logic [DATA_W-1:0] data
);
  import vliw_pkg::*;

  logic [7:0] byte_sel;

  // Pick the addressed byte lane, then zero/sign extend; word loads pass through
  always_comb begin
    byte_sel = readData[7:0];
    case (addr)
      LANE0:   byte_sel = readData[7:0];
      LANE1:   byte_sel = readData[15:8];
      LANE2:   byte_sel = readData[23:16];
      LANE3:   byte_sel = readData[31:24];
      default: byte_sel = readData[7:0];
    endcase
    if (!loadByte) begin
      data = readData;
    end else if (loadSigned) begin
      data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
    end else begin
      data = {{(DATA_W-8){1'b0}}, byte_sel};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, collision resolve, halt state, retire counter
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p4_pipeline_regWrite,
  input  logic              WB_flush,
  input  logic              p3_valid,
  input  logic              p3_alu_regWrite,
  input  logic              p3_mem_regWrite,
  input  logic [REG_W-1:0]  p3_alu_rd,
  input  logic [REG_W-1:0]  p3_mem_rd,
  input  logic [DATA_W-1:0] p3_alu_aluOut,
  input  logic [DATA_W-1:0] p3_mem_readData,
  input  logic [DATA_W-1:0] p3_mem_address,
  input  logic              p3_mem_loadByte,
  input  logic              p3_mem_loadSigned,
  input  logic              p3_isException,
  output logic              p4_alu_regWrite,
  output logic              p4_mem_regWrite,
  output logic [REG_W-1:0]  p4_alu_rd,
  output logic [REG_W-1:0]  p4_mem_rd,
  output logic [DATA_W-1:0] p4_alu_writeData,
  output logic [DATA_W-1:0] p4_mem_writeData,
  output logic              halted,
  output logic [CNT_W-1:0]  retiredBundles
);
  import vliw_pkg::*;

  wb_state_t         state, state_n;
  logic              alu_we_n, mem_we_n;
  logic [REG_W-1:0]  alu_rd_n, mem_rd_n;
  logic [DATA_W-1:0] alu_data_n, mem_data_n;
  logic [CNT_W-1:0]  cnt_n;

  logic [DATA_W-1:0] load_data;
  logic              align_fault, bundle_fault, collide, capture;
  logic              unused_addr;

  // Only the low two address bits select a lane
  assign unused_addr = ^p3_mem_address[DATA_W-1:2];

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .readData   (p3_mem_readData),
    .addr       (p3_mem_address[1:0]),
    .loadByte   (p3_mem_loadByte),
    .loadSigned (p3_mem_loadSigned),
    .data       (load_data)
  );

  // Next-state: capture decision, fault/collision resolution, halt and retire count
  always_comb begin
    state_n    = state;
    alu_we_n   = p4_alu_regWrite;
    mem_we_n   = p4_mem_regWrite;
    alu_rd_n   = p4_alu_rd;
    mem_rd_n   = p4_mem_rd;
    alu_data_n = p4_alu_writeData;
    mem_data_n = p4_mem_writeData;
    cnt_n      = retiredBundles;

    align_fault  = p3_mem_regWrite && !p3_mem_loadByte && (p3_mem_address[1:0] != 2'd0);
    bundle_fault = p3_valid && (p3_isException || align_fault);
    collide      = p3_alu_regWrite && p3_mem_regWrite && (p3_alu_rd == p3_mem_rd);
    capture      = WB_flush || p4_pipeline_regWrite;

    if (capture) begin
      if (WB_flush || state == HALTED) begin
        // Bubble: nothing writes, flush masks any fault in the same cycle
        alu_we_n   = 1'b0;
        mem_we_n   = 1'b0;
        alu_rd_n   = '0;
        mem_rd_n   = '0;
        alu_data_n = '0;
        mem_data_n = '0;
      end else begin
        alu_we_n   = p3_valid && p3_alu_regWrite && !collide && !bundle_fault;
        mem_we_n   = p3_valid && p3_mem_regWrite && !bundle_fault;
        alu_rd_n   = p3_alu_rd;
        mem_rd_n   = p3_mem_rd;
        alu_data_n = p3_alu_aluOut;
        mem_data_n = load_data;
        if (bundle_fault) begin
          state_n = HALTED;
        end else if (p3_valid) begin
          cnt_n = retiredBundles + 1'b1;
        end
      end
    end
  end

  // MEM/WB register, architectural state and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      p4_alu_regWrite  <= 1'b0;
      p4_mem_regWrite  <= 1'b0;
      p4_alu_rd        <= '0;
      p4_mem_rd        <= '0;
      p4_alu_writeData <= '0;
      p4_mem_writeData <= '0;
      retiredBundles   <= '0;
    end else begin
      state            <= state_n;
      p4_alu_regWrite  <= alu_we_n;
      p4_mem_regWrite  <= mem_we_n;
      p4_alu_rd        <= alu_rd_n;
      p4_mem_rd        <= mem_rd_n;
      p4_alu_writeData <= alu_data_n;
      p4_mem_writeData <= mem_data_n;
      retiredBundles   <= cnt_n;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              p4_pipeline_regWrite;
  logic              WB_flush;
  logic              p3_valid;
  logic              p3_alu_regWrite;
  logic              p3_mem_regWrite;
  logic [REG_W-1:0]  p3_alu_rd;
  logic [REG_W-1:0]  p3_mem_rd;
  logic [DATA_W-1:0] p3_alu_aluOut;
  logic [DATA_W-1:0] p3_mem_readData;
  logic [DATA_W-1:0] p3_mem_address;
  logic              p3_mem_loadByte;
  logic              p3_mem_loadSigned;
  logic              p3_isException;
  logic              p4_alu_regWrite;
  logic              p4_mem_regWrite;
  logic [REG_W-1:0]  p4_alu_rd;
  logic [REG_W-1:0]  p4_mem_rd;
  logic [DATA_W-1:0] p4_alu_writeData;
  logic [DATA_W-1:0] p4_mem_writeData;
  logic              halted;
  logic [CNT_W-1:0]  retiredBundles;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .p4_pipeline_regWrite (p4_pipeline_regWrite),
    .WB_flush             (WB_flush),
    .p3_valid             (p3_valid),
    .p3_alu_regWrite      (p3_alu_regWrite),
    .p3_mem_regWrite      (p3_mem_regWrite),
    .p3_alu_rd            (p3_alu_rd),
    .p3_mem_rd            (p3_mem_rd),
    .p3_alu_aluOut        (p3_alu_aluOut),
    .p3_mem_readData      (p3_mem_readData),
    .p3_mem_address       (p3_mem_address),
    .p3_mem_loadByte      (p3_mem_loadByte),
    .p3_mem_loadSigned    (p3_mem_loadSigned),
    .p3_isException       (p3_isException),
    .p4_alu_regWrite      (p4_alu_regWrite),
    .p4_mem_regWrite      (p4_mem_regWrite),
    .p4_alu_rd            (p4_alu_rd),
    .p4_mem_rd            (p4_mem_rd),
    .p4_alu_writeData     (p4_alu_writeData),
    .p4_mem_writeData     (p4_mem_writeData),
    .halted               (halted),
    .retiredBundles       (retiredBundles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p4_pipeline_regWrite = 1'b1;
    WB_flush             = 1'b0;
    p3_valid             = 1'b0;
    p3_alu_regWrite      = 1'b0;
    p3_mem_regWrite      = 1'b0;
    p3_alu_rd            = '0;
    p3_mem_rd            = '0;
    p3_alu_aluOut        = '0;
    p3_mem_readData      = '0;
    p3_mem_address       = '0;
    p3_mem_loadByte      = 1'b0;
    p3_mem_loadSigned    = 1'b0;
    p3_isException       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got we=%b%b rd=%0d/%0d, want all 0",
               p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd);
    end
    checks++;
    if (p4_alu_writeData !== 32'd0 || p4_mem_writeData !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h, want 0/0", p4_alu_writeData, p4_mem_writeData);
    end
    checks++;
    if (halted !== 1'b0 || retiredBundles !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got halted=%b cnt=%0d, want 0/0", halted, retiredBundles);
    end
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h00000001;
    exp_data[1] = 32'h0000007F;
    exp_data[2] = 32'hFFFFFFFF;
    exp_data[3] = 32'hFFFFFF80;
    idle_inputs();
    p3_valid          = 1'b1;
    p3_mem_regWrite   = 1'b1;
    p3_mem_rd         = 3'd1;
    p3_mem_readData   = 32'h80FF7F01;
    p3_mem_loadByte   = 1'b1;
    p3_mem_loadSigned = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p3_mem_address = 32'h2000 + 32'(i);
      step();
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (p4_mem_regWrite !== 1'b1 || p4_mem_writeData !== exp_data[i]) begin
        errors++;
        $display("FAIL byte_signed_lane%0d: got we=%b data=%h, want we=1 data=%h",
                 i, p4_mem_regWrite, p4_mem_writeData, exp_data[i]);
      end
    end
    checks++;
    if (retiredBundles !== 4'd4) begin
      errors++;
      $display("FAIL byte_count: got %0d, want 4", retiredBundles);
    end
    p3_mem_loadSigned = 1'b0;
    p3_mem_address    = 32'h2003;
    step();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (p4_mem_writeData !== 32'h00000080) begin
      errors++;
      $display("FAIL byte_unsigned_lane3: got %h, want 00000080", p4_mem_writeData);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    p3_valid        = 1'b1;
    p3_alu_regWrite = 1'b1;
    p3_mem_regWrite = 1'b1;
    p3_alu_rd       = 3'd3;
    p3_mem_rd       = 3'd3;
    p3_alu_aluOut   = 32'd5;
    p3_mem_readData = 32'd9;
    p3_mem_address  = 32'h100;
    step();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (p4_mem_regWrite !== 1'b1 || p4_mem_writeData !== 32'd9 || p4_alu_regWrite !== 1'b0) begin
      errors++;
      $display("FAIL collision_same_rd: got mem_we=%b mem_data=%0d alu_we=%b, want 1/9/0",
               p4_mem_regWrite, p4_mem_writeData, p4_alu_regWrite);
    end
    p3_mem_rd = 3'd4;
    step();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (p4_alu_regWrite !== 1'b1 || p4_mem_regWrite !== 1'b1 || p4_alu_writeData !== 32'd5 ||
        p4_alu_rd !== 3'd3 || p4_mem_rd !== 3'd4) begin
      errors++;
      $display("FAIL collision_diff_rd: got we=%b%b rd=%0d/%0d alu_data=%0d, want 11 3/4 5",
               p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd, p4_alu_writeData);
    end
    checks++;
    if (retiredBundles !== exp_cnt) begin
      errors++;
      $display("FAIL collision_count: got %0d, want %0d", retiredBundles, exp_cnt);
    end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    p3_valid        = 1'b1;
    p3_alu_regWrite = 1'b1;
    p3_alu_rd       = 3'd2;
    p3_alu_aluOut   = 32'h11;
    step();
    exp_cnt = exp_cnt + 1'b1;
    p3_alu_aluOut        = 32'h22;
    p3_alu_rd            = 3'd6;
    p4_pipeline_regWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (p4_alu_writeData !== 32'h11 || p4_alu_rd !== 3'd2 || p4_alu_regWrite !== 1'b1 ||
          retiredBundles !== exp_cnt) begin
        errors++;
        $display("FAIL stall_hold_%0d: got data=%h rd=%0d we=%b cnt=%0d, want 11/2/1/%0d",
                 i, p4_alu_writeData, p4_alu_rd, p4_alu_regWrite, retiredBundles, exp_cnt);
      end
    end
    WB_flush       = 1'b1;
    p3_isException = 1'b1;
    step();
    checks++;
    if (p4_alu_regWrite !== 1'b0 || p4_alu_writeData !== 32'd0 || halted !== 1'b0 ||
        retiredBundles !== exp_cnt) begin
      errors++;
      $display("FAIL flush_bubble: got we=%b data=%h halted=%b cnt=%0d, want 0/0/0/%0d",
               p4_alu_regWrite, p4_alu_writeData, halted, retiredBundles, exp_cnt);
    end
  endtask

  task automatic test_fault_halt();
    idle_inputs();
    p3_valid        = 1'b1;
    p3_alu_regWrite = 1'b1;
    p3_alu_rd       = 3'd5;
    p3_mem_regWrite = 1'b1;
    p3_mem_rd       = 3'd6;
    p3_mem_address  = 32'h1002;
    p3_mem_readData = 32'hDEADBEEF;
    step();
    checks++;
    if (p4_alu_regWrite !== 1'b0 || p4_mem_regWrite !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_halt: got we=%b%b halted=%b, want 00 1",
               p4_alu_regWrite, p4_mem_regWrite, halted);
    end
    p3_mem_address = 32'h1000;
    step();
    checks++;
    if (p4_alu_regWrite !== 1'b0 || p4_mem_regWrite !== 1'b0 || retiredBundles !== exp_cnt) begin
      errors++;
      $display("FAIL halted_frozen: got we=%b%b cnt=%0d, want 00 %0d",
               p4_alu_regWrite, p4_mem_regWrite, retiredBundles, exp_cnt);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = '0;
    checks++;
    if (halted !== 1'b0 || retiredBundles !== 4'd0) begin
      errors++;
      $display("FAIL halt_reset: got halted=%b cnt=%0d, want 0/0", halted, retiredBundles);
    end
  endtask

  task automatic test_counter_wrap();
    idle_inputs();
    p3_valid        = 1'b1;
    p3_alu_regWrite = 1'b1;
    p3_alu_rd       = 3'd1;
    for (int i = 0; i < 17; i++) begin
      p3_alu_aluOut = 32'(i);
      step();
    end
    checks++;
    if (retiredBundles !== 4'd1) begin
      errors++;
      $display("FAIL counter_wrap: got %0d, want 1", retiredBundles);
    end
  endtask

  initial begin
    reset = 1'b1;
    exp_cnt = '0;
    idle_inputs();
    test_reset();
    test_byte_loads();
    test_collision();
    test_stall_flush();
    test_fault_halt();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the two-slot (ALU + MEM) VLIW pipeline, directly downstream of the MEM stage. It captures the MEM/WB pipeline register, aligns and extends load data, and resolves same-bundle destination collisions. It drives the two register-file write ports and the p4 forwarding values back into EX. It also owns the architectural halt-on-exception state and a retired-bundle counter.

## Interface
- DATA_W, 32, datapath width
- REG_W, 3, register address width (8 registers)
- CNT_W, 32, retired-bundle counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is sampled high
- p4_pipeline_regWrite  in  1  MEM/WB register enable; 0 = stall, hold contents
- WB_flush  in  1  load a bubble; has priority over p4_pipeline_regWrite=0
- p3_valid  in  1  bundle present at MEM output
- p3_alu_regWrite, p3_mem_regWrite  in  1 each  slot write enables
- p3_alu_rd, p3_mem_rd  in  REG_W each  destination registers
- p3_alu_aluOut  in  DATA_W  ALU result
- p3_mem_readData  in  DATA_W  raw memory word
- p3_mem_address  in  DATA_W  effective address; only [1:0] used
- p3_mem_loadByte, p3_mem_loadSigned  in  1 each  load size / extension
- p3_isException  in  1  exception flagged by an earlier stage for this bundle
- p4_alu_regWrite, p4_mem_regWrite  out  1 each  register-file write enables
- p4_alu_rd, p4_mem_rd  out  REG_W each  write addresses
- p4_alu_writeData, p4_mem_writeData  out  DATA_W each  write data, also the p4 forwarding sources for EX
- halted  out  1  pipeline halted on exception
- retiredBundles  out  CNT_W  count of committed bundles

## Operation
- Capture when reset=0 and (WB_flush or p4_pipeline_regWrite). Flush captures a bubble: valid=0, both regWrites=0, data=0.
- Load alignment:
  - Word load: data = readData.
  - Byte load: lane = address[1:0], little-endian (lane 0 = bits 7:0). Zero- or sign-extended per loadSigned.
- Alignment fault: word load (mem_regWrite=1, loadByte=0) with address[1:0]≠0.
- Bundle fault: valid and (p3_isException or alignment fault).
- Collision: both regWrites=1 and alu_rd==mem_rd. MEM slot wins; the ALU write enable is cleared in the captured register.
- States: RUN, HALTED.
  - RUN→HALTED when a faulting bundle is captured. That bundle's writes are suppressed (both enables 0).
  - HALTED is left only by reset. While HALTED, captured bundles are forced to bubbles and retiredBundles is frozen.
- retiredBundles increments by 1 on every capture edge in RUN of a valid, non-faulting bundle. Wraps at 2^CNT_W−1 → 0.
- Outputs come from the registered MEM/WB contents only. No combinational path from p3 inputs to outputs.

## Timing
- Latency: 1 cycle from p3 inputs to p4 outputs. The register file writes on the following edge (owned by ID).
- Reset values: all p4 outputs 0, halted=0, retiredBundles=0, state RUN.
- Stall (enable=0, flush=0): all outputs and the counter hold. A pending fault is not sampled until capture.
- Flush and a faulting bundle in the same cycle: flush wins; no halt.
- Reset asserted mid-stall or while HALTED: next edge returns to the reset values.
- Halt takes effect on the same edge the faulting bundle is captured, so that bundle never writes.

## Structure
- Shared package vliw_pkg: DATA_W, REG_W, the wb_state_t enum (RUN, HALTED), and the lane-select constants.
- One sub-module, load_align: purely combinational byte-lane select and extend (readData, addr[1:0], loadByte, loadSigned → data). It is reused by any future load-forwarding path.
- Single always block for the MEM/WB register, state and counter.

## Test plan
- Reset: hold reset 2 cycles → all outputs 0, halted=0, retiredBundles=0.
- Byte loads: readData=0x80FF7F01, byte signed at addresses …0/…1/…2/…3 → mem_writeData 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Unsigned lane 3 → 0x00000080. Counter goes 0→4.
- Collision: alu_rd=mem_rd=3, both writing, aluOut=5, load=9 → p4_mem_regWrite=1 with data 9, p4_alu_regWrite=0. Different rd (3, 4) → both 1.
- Misaligned word load at 0x1002 → both enables 0, halted=1 next cycle. A following valid bundle → enables stay 0 and the counter is frozen. Reset → halted=0.
- Stall/flush: valid bundle with enable=0 for 3 cycles → outputs and counter unchanged. Then flush=1 together with p3_isException=1 → bubble, halted stays 0.
- Counter wrap: with CNT_W=4, 17 valid bundles → retiredBundles=1.
